eth_regbus_axis_tx: RTL and testbench
=====================================

ETH_REGBUS_AXIS_TX -- requirements
Module: eth_regbus_axis_tx

Interface
REQ-001 SHALL have parameter FifoDepth, default 4, meaning beat FIFO depth; legal range 2..16.
REQ-002 SHALL have port clk_i, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port reg_req_i, input, eth_top_pkg::reg_bus_req_t: register-bus request with fields valid, write, addr[3:0], wdata[31:0], wstrb[3:0].
REQ-005 SHALL have port reg_rsp_o, output, eth_top_pkg::reg_bus_rsp_t: register-bus response with fields ready, error, rdata[31:0].
REQ-006 SHALL have port tx_req_o, output, eth_top_pkg::s_req_t: AXI-Stream master with tvalid and t fields tdata[63:0], tstrb[7:0], tkeep[7:0], tlast, tuser[0:0], tid, tdest.
REQ-007 SHALL have port tx_rsp_i, input, eth_top_pkg::s_rsp_t: AXI-Stream tready.

Function
REQ-008 SHALL implement the register map 0x0 DATA_LO, 0x4 DATA_HI, 0x8 CTRL, 0xC STATUS, decoded on addr[3:2].
REQ-009 SHALL assert reg_rsp_o.ready in the same cycle as reg_req_i.valid, giving zero-wait-state access.
REQ-010 SHALL set reg_rsp_o.error when valid is high and addr[1:0] != 0, and SHALL then cause no state change.
REQ-011 DATA_LO/DATA_HI writes SHALL update staging bits [31:0] or [63:32] bytewise per wstrb; reads SHALL return the staged value.
REQ-012 CTRL write SHALL ignore wstrb and take the fields keep = wdata[7:0], last = wdata[8], user = wdata[9].
REQ-013 CTRL write SHALL push {staging, keep, last, user} into the FIFO when level < FifoDepth; staging SHALL NOT be cleared by the push.
REQ-014 CTRL write with level == FifoDepth SHALL drop the beat, set error = 1 and set sticky OVF; a pop in the same cycle SHALL NOT make room.
REQ-015 CTRL read SHALL return the last accepted CTRL fields in bits [9:0], zero elsewhere.
REQ-016 STATUS read SHALL return the following fields:
  - [4:0] level
  - [8] empty
  - [9] full
  - [10] OVF
  - [31:16] frame count
REQ-017 STATUS write with wdata[10] = 1 and wstrb[1] = 1 SHALL clear OVF; other STATUS bits SHALL be read-only.
REQ-018 Frame count SHALL increment on every handshake (tvalid & tready) with tlast = 1 and SHALL wrap from 0xFFFF to 0x0000.
REQ-019 tvalid SHALL equal !empty.
  - tdata, tkeep, tlast and tuser SHALL come from the FIFO head.
  - tstrb SHALL equal tkeep.
  - tid and tdest SHALL be driven 0.
REQ-020 A beat pushed into an empty FIFO SHALL appear with tvalid = 1 on the cycle after the CTRL write (latency 1).
REQ-021 Once tvalid is high, the beat SHALL remain stable until tready is sampled high (AXI-Stream rule).
REQ-022 A pop SHALL occur on tvalid & tready.
  - Simultaneous push and pop with 0 < level < FifoDepth SHALL leave level unchanged and preserve order.
REQ-023 FIFO pointers SHALL wrap modulo FifoDepth.
  - level SHALL never exceed FifoDepth.
  - level SHALL never underflow.
REQ-024 Outputs SHALL have no combinational path from tx_rsp_i to tx_req_o.

Reset
REQ-025 On rst_i = 1 at a clock edge, the following SHALL be cleared:
  - level, the pointers and the frame count SHALL go to 0.
  - Staging data SHALL go to 0, and the CTRL fields and OVF SHALL go to 0.
  - tvalid SHALL go to 0, and tdata, tkeep and tstrb SHALL go to 0.
REQ-026 Reset asserted mid-frame SHALL discard all queued beats without emitting them and without counting a frame.
REQ-027 During reset, reg_rsp_o SHALL be ready = 1 and error = 0, and SHALL ignore requests.

Verification
REQ-028 Write DATA_LO = 0x11223344, DATA_HI = 0x55667788, then CTRL = 0x1FF with tready = 1 -> one cycle later tvalid = 1 with:
  - tdata = 0x5566778811223344
  - tkeep = 0xFF and tlast = 1
  - After the handshake, STATUS[31:16] = 1.
REQ-029 With tready = 0, push 4 beats and then a fifth -> the fifth response has error = 1; STATUS = full = 1, level = 4, OVF = 1; writing STATUS 0x400 clears OVF.
REQ-030 Push 3 beats with keep 0x01/0x03/0x0F and last on the third, then toggle tready 1,0,1,0,1 -> beats emerge in order, held stable while tready = 0, and the frame count increments once.
REQ-031 With level = 2, do a CTRL write in the same cycle as a handshake -> level stays 2 and output order is preserved.
REQ-032 Assert rst_i with 3 beats queued -> the next cycle has tvalid = 0, STATUS = 0x00000100, and no frame is counted.
REQ-033 Access addr 0x2, and write DATA_LO with wstrb = 0x4 and wdata 0xAABBCCDD -> the first has error = 1 with no change; the second changes only byte 2 to 0xBB.

Source files
------------

// File: rtl/eth_regbus_axis_tx.sv
// Register-bus to AXI-Stream transmit bridge.
// CPU stages 64-bit beats through registers and queues them into a small FIFO.
package eth_top_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic        error;
        logic [31:0] rdata;
    } reg_bus_rsp_t;

    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tstrb;
        logic [7:0]  tkeep;
        logic        tlast;
        logic [0:0]  tuser;
        logic [0:0]  tid;
        logic [0:0]  tdest;
    } s_t;

    typedef struct packed {
        logic tvalid;
        s_t   t;
    } s_req_t;

    typedef struct packed {
        logic tready;
    } s_rsp_t;

endpackage

module eth_regbus_axis_tx
    import eth_top_pkg::*;
#(
    parameter int FifoDepth = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  reg_bus_req_t reg_req_i,
    output reg_bus_rsp_t reg_rsp_o,
    output s_req_t       tx_req_o,
    input  s_rsp_t       tx_rsp_i
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    beat_t           mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [4:0]      level;
    logic [63:0]     stage;
    logic [9:0]      ctrl_q;
    logic            ovf;
    logic [15:0]     frame_cnt;

    logic       acc;
    logic       misal;
    logic       ok;
    logic       wr;
    logic [1:0] sel;
    logic       full;
    logic       empty;
    logic       push_req;
    logic       push;
    logic       drop;
    logic       pop;
    logic       ovf_clr;
    beat_t      head;

    function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Requests are ignored while reset is held.
    assign acc      = reg_req_i.valid & ~rst_i;
    assign misal    = reg_req_i.addr[1:0] != 2'b00;
    assign ok       = acc & ~misal;
    assign wr       = ok & reg_req_i.write;
    assign sel      = reg_req_i.addr[3:2];
    assign full     = level == 5'(FifoDepth);
    assign empty    = level == 5'd0;
    // Fullness is judged before any same-cycle pop, so a pop never makes room.
    assign push_req = wr & (sel == 2'd2);
    assign push     = push_req & ~full;
    assign drop     = push_req & full;
    assign pop      = ~empty & tx_rsp_i.tready;
    assign ovf_clr  = wr & (sel == 2'd3) & reg_req_i.wdata[10] & reg_req_i.wstrb[1];
    assign head     = mem[rd_ptr];

    // Zero-wait-state response and read mux.
    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = 1'b1;
        reg_rsp_o.error = acc & (misal | drop);
        if (ok & ~reg_req_i.write) begin
            unique case (sel)
                2'd0: reg_rsp_o.rdata = stage[31:0];
                2'd1: reg_rsp_o.rdata = stage[63:32];
                2'd2: reg_rsp_o.rdata = {22'd0, ctrl_q};
                2'd3: reg_rsp_o.rdata = {frame_cnt, 5'd0, ovf, full, empty, 3'd0, level};
            endcase
        end
    end

    // Stream outputs depend only on registered FIFO state, never on tready.
    always_comb begin
        tx_req_o          = '0;
        tx_req_o.tvalid   = ~empty;
        if (!empty) begin
            tx_req_o.t.tdata = head.data;
            tx_req_o.t.tkeep = head.keep;
            tx_req_o.t.tstrb = head.keep;
            tx_req_o.t.tlast = head.last;
            tx_req_o.t.tuser = head.user;
        end
    end

    // Beat storage; contents are don't-care until pushed.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem[wr_ptr] <= '{data: stage,
                             keep: reg_req_i.wdata[7:0],
                             last: reg_req_i.wdata[8],
                             user: reg_req_i.wdata[9]};
        end
    end

    // Control state: pointers, level, staging, CTRL fields, overflow, frame count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            stage     <= '0;
            ctrl_q    <= '0;
            ovf       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (wr && sel == 2'd0) begin
                for (int b = 0; b < 4; b++) begin
                    if (reg_req_i.wstrb[b]) begin
                        stage[8*b +: 8] <= reg_req_i.wdata[8*b +: 8];
                    end
                end
            end
            if (wr && sel == 2'd1) begin
                for (int b = 0; b < 4; b++) begin
                    if (reg_req_i.wstrb[b]) begin
                        stage[32+8*b +: 8] <= reg_req_i.wdata[8*b +: 8];
                    end
                end
            end
            if (push) begin
                wr_ptr <= bump(wr_ptr);
                ctrl_q <= reg_req_i.wdata[9:0];
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
                if (head.last) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
            level <= level + {4'd0, push} - {4'd0, pop};
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_regbus_axis_tx.sv
// Bench for eth_regbus_axis_tx: queue-based reference model,
// per-cycle stream compare, and directed register scenarios.
module tb_eth_regbus_axis_tx;
    import eth_top_pkg::*;

    localparam int DEPTH = 4;

    logic         clk;
    logic         rst;
    reg_bus_req_t req;
    reg_bus_rsp_t rsp;
    s_req_t       txq;
    s_rsp_t       txr;

    eth_regbus_axis_tx #(.FifoDepth(DEPTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .reg_req_i(req),
        .reg_rsp_o(rsp),
        .tx_req_o (txq),
        .tx_rsp_i (txr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } mbeat_t;

    mbeat_t      q[$];
    logic [63:0] m_stage = '0;
    logic [9:0]  m_ctrl  = '0;
    bit          m_ovf   = 0;
    logic [15:0] m_fc    = '0;
    bit          live    = 0;
    bit          hold    = 0;
    s_t          snap;

    function automatic logic [31:0] m_status();
        return {m_fc, 5'd0, m_ovf, q.size() == DEPTH, q.size() == 0,
                3'd0, 5'(q.size())};
    endfunction

    // Reference model: apply each cycle's request and handshake at the edge.
    always @(posedge clk) begin : model
        int pre;
        bit dpop;
        bit dpush;
        hold = live && !rst && txq.tvalid && !txr.tready;
        snap = txq.t;
        if (rst) begin
            q.delete();
            m_stage = '0;
            m_ctrl  = '0;
            m_ovf   = 0;
            m_fc    = '0;
            live    = 1;
        end else begin
            pre   = q.size();
            dpop  = pre > 0 && txr.tready;
            dpush = 0;
            if (req.valid && req.write && req.addr[1:0] == 2'b00) begin
                case (req.addr[3:2])
                    2'd0, 2'd1: begin
                        for (int b = 0; b < 4; b++) begin
                            if (req.wstrb[b]) begin
                                m_stage[32*req.addr[2] + 8*b +: 8] = req.wdata[8*b +: 8];
                            end
                        end
                    end
                    2'd2: begin
                        if (pre < DEPTH) begin
                            dpush  = 1;
                            m_ctrl = req.wdata[9:0];
                        end else begin
                            m_ovf = 1;
                        end
                    end
                    default: begin
                        if (req.wdata[10] && req.wstrb[1]) m_ovf = 0;
                    end
                endcase
            end
            if (dpop) begin
                if (q[0].l) m_fc = m_fc + 16'd1;
                void'(q.pop_front());
            end
            if (dpush) begin
                q.push_back('{d: m_stage, k: req.wdata[7:0],
                              l: req.wdata[8], u: req.wdata[9]});
            end
        end
    end

    // Stream compare on every falling edge once the model is live.
    always @(negedge clk) begin
        if (live) begin
            check("tvalid", txq.tvalid, q.size() != 0);
            check("tid_tdest", {txq.t.tid, txq.t.tdest}, 0);
            check("tstrb_eq_tkeep", txq.t.tstrb, txq.t.tkeep);
            if (q.size() != 0) begin
                check("tdata", txq.t.tdata, q[0].d);
                check("tkeep", txq.t.tkeep, q[0].k);
                check("tlast_tuser", {txq.t.tlast, txq.t.tuser}, {q[0].l, q[0].u});
            end
            if (hold) begin
                check("hold_tdata", txq.t.tdata, snap.tdata);
                check("hold_ctl", {txq.t.tkeep, txq.t.tlast, txq.t.tuser},
                      {snap.tkeep, snap.tlast, snap.tuser});
            end
        end
    end

    bit          rst_drv = 1;
    logic [31:0] last_rd;
    logic        last_er;

    task automatic cyc(input bit v, input bit w, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] s, input bit tr);
        logic        e;
        logic [31:0] exp_rd;
        @(negedge clk);
        rst       = rst_drv;
        req.valid = v;
        req.write = w;
        req.addr  = a;
        req.wdata = d;
        req.wstrb = s;
        txr.tready = tr;
        #1;
        e = !rst && v && (a[1:0] != 2'b00 ||
                          (a[3:2] == 2'd2 && w && q.size() >= DEPTH));
        check("rsp_ready", rsp.ready, 1);
        check("rsp_error", rsp.error, e);
        if (!rst && v && !w && !e) begin
            case (a[3:2])
                2'd0:    exp_rd = m_stage[31:0];
                2'd1:    exp_rd = m_stage[63:32];
                2'd2:    exp_rd = {22'd0, m_ctrl};
                default: exp_rd = m_status();
            endcase
            check("rdata", rsp.rdata, exp_rd);
        end
        last_rd = rsp.rdata;
        last_er = rsp.error;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit tr);
        cyc(1, 1, a, d, s, tr);
    endtask

    task automatic rdr(input logic [3:0] a, input bit tr);
        cyc(1, 0, a, 32'd0, 4'd0, tr);
    endtask

    task automatic idle(input bit tr);
        cyc(0, 0, 4'd0, 32'd0, 4'd0, tr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 0;
        rst = 1;
        req = '0;
        txr = '0;

        // Reset with a CTRL write pending: ignored, ready=1, error=0.
        rst_drv = 1;
        wr(4'h8, 32'h1FF, 4'hF, 0);
        wr(4'h8, 32'h1FF, 4'hF, 0);
        check("rst_err", last_er, 0);
        check("rst_tvalid", txq.tvalid, 0);
        check("rst_tdata", txq.t.tdata, 0);
        check("rst_tkeep", {txq.t.tkeep, txq.t.tstrb}, 0);
        rst_drv = 0;
        rdr(4'hC, 0);
        check("status_reset", last_rd, 32'h0000_0100);

        // Single beat, latency 1, frame counted.
        wr(4'h0, 32'h11223344, 4'hF, 1);
        wr(4'h4, 32'h55667788, 4'hF, 1);
        wr(4'h8, 32'h0000_01FF, 4'hF, 1);
        idle(1);
        check("lat1_tvalid", txq.tvalid, 1);
        check("lat1_tdata", txq.t.tdata, 64'h5566778811223344);
        check("lat1_tkeep", txq.t.tkeep, 8'hFF);
        check("lat1_tlast", txq.t.tlast, 1);
        rdr(4'hC, 1);
        check("status_fc1", last_rd, 32'h0001_0100);

        // Overflow: four beats fill, fifth dropped.
        wr(4'h8, 32'h001, 4'hF, 0);
        wr(4'h8, 32'h003, 4'hF, 0);
        wr(4'h8, 32'h00F, 4'hF, 0);
        wr(4'h8, 32'h0FF, 4'hF, 0);
        wr(4'h8, 32'h1FF, 4'hF, 0);
        check("ovf_err", last_er, 1);
        rdr(4'hC, 0);
        check("status_full", last_rd, 32'h0001_0604);
        wr(4'hC, 32'h400, 4'b0010, 0);
        rdr(4'hC, 0);
        check("status_ovf_clr", last_rd, 32'h0001_0204);
        rdr(4'h8, 0);
        check("ctrl_rd", last_rd, 32'h0000_00FF);
        repeat (4) idle(1);
        idle(0);

        // Three-beat frame with tready toggling.
        wr(4'h0, 32'hA0A0A0A0, 4'hF, 0);
        wr(4'h8, 32'h001, 4'hF, 0);
        wr(4'h0, 32'hB1B1B1B1, 4'hF, 0);
        wr(4'h8, 32'h003, 4'hF, 0);
        wr(4'h0, 32'hC2C2C2C2, 4'hF, 0);
        wr(4'h8, 32'h30F, 4'hF, 0);
        idle(0);
        check("frm_head_keep", txq.t.tkeep, 8'h01);
        check("frm_head_data", txq.t.tdata, 64'h55667788A0A0A0A0);
        idle(1);
        idle(0);
        idle(1);
        idle(0);
        check("frm_last_keep", txq.t.tkeep, 8'h0F);
        check("frm_last_flags", {txq.t.tlast, txq.t.tuser}, 2'b11);
        idle(1);
        rdr(4'hC, 0);
        check("status_fc2", last_rd, 32'h0002_0100);

        // Push and pop together at level 2.
        wr(4'h8, 32'h0FF, 4'hF, 0);
        wr(4'h8, 32'h0FF, 4'hF, 0);
        wr(4'h8, 32'h0AA, 4'hF, 1);
        rdr(4'hC, 0);
        check("status_lvl2", last_rd, 32'h0002_0002);
        repeat (2) idle(1);
        idle(0);

        // Reset with three beats queued.
        wr(4'h8, 32'h1FF, 4'hF, 0);
        wr(4'h8, 32'h1FF, 4'hF, 0);
        wr(4'h8, 32'h1FF, 4'hF, 0);
        rst_drv = 1;
        idle(0);
        rst_drv = 0;
        rdr(4'hC, 1);
        check("rst_mid_tvalid", txq.tvalid, 0);
        check("rst_mid_status", last_rd, 32'h0000_0100);

        // Misaligned access and byte-lane write.
        rdr(4'h2, 0);
        check("misal_rd_err", last_er, 1);
        wr(4'h2, 32'h12345678, 4'hF, 0);
        check("misal_wr_err", last_er, 1);
        rdr(4'h0, 0);
        check("misal_nochg", last_rd, 32'h0);
        wr(4'h0, 32'h11223344, 4'hF, 0);
        wr(4'h0, 32'hAABBCCDD, 4'h4, 0);
        rdr(4'h0, 0);
        check("byte2_only", last_rd, 32'h11BB3344);
        rdr(4'h4, 0);
        check("data_hi_reset", last_rd, 32'h0);
        idle(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
